// File: rtl/cpu_pkg.sv
// Opcode encodings, sequencer state enum and instruction-class decode helpers
// shared by the CPU control path.
package cpu_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_ROR  = 5'b00111;
  localparam opcode_t OP_ROL  = 5'b01000;
  localparam opcode_t OP_SHR  = 5'b01001;
  localparam opcode_t OP_SHRA = 5'b01010;
  localparam opcode_t OP_SHL  = 5'b01011;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_DIV  = 5'b01111;
  localparam opcode_t OP_MUL  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_BRX  = 5'b10011;
  localparam opcode_t OP_JR   = 5'b10100;
  localparam opcode_t OP_JAL  = 5'b10101;
  localparam opcode_t OP_IN   = 5'b10110;
  localparam opcode_t OP_OUT  = 5'b10111;
  localparam opcode_t OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  // T0..T7 encode their own step number so the low bits double as a step index.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RST = 4'd8, S_HALT = 4'd9
  } state_t;

  function automatic logic is_alu3(opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  function automatic logic is_imm(opcode_t op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

  function automatic logic is_unary(opcode_t op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(opcode_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_mem(opcode_t op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  // Final execute step; single-step classes (and unused opcodes) end at T3.
  function automatic logic [2:0] last_step(opcode_t op);
    if ((op == OP_LD) || (op == OP_ST))                      return 3'd7;
    if (is_muldiv(op) || (op == OP_BRX))                     return 3'd6;
    if (is_alu3(op) || is_imm(op) || (op == OP_LDI))         return 3'd5;
    if (is_unary(op) || (op == OP_JAL))                      return 3'd4;
    return 3'd3;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired multi-cycle sequencer: fetch T0-T2, class-specific execute steps,
// Moore-decoded datapath controls, with reset/halt handling.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [4:0]  opcode,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        PCout, PCin, incPC, IRin, MARin, MDRin, MDRout, read, write,
  output logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Cout,
  output logic        InPortOut, OutPortIn, CONN_in, jal_flag, R15jal,
  output logic        run,
  output logic        clear
);

  state_t     state, state_nx;
  opcode_t    op;
  logic [3:0] step;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign step      = state;
  assign unused_ir = ^ir[26:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_nx;
  end

  // stop only matters on the step that would otherwise return to T0
  always_comb begin
    state_nx = S_RST;
    case (state)
      S_RST:  state_nx = S_T0;
      S_HALT: state_nx = S_HALT;
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if ((state == S_T3) && (op == OP_HALT))   state_nx = S_HALT;
        else if (step[2:0] == last_step(op))      state_nx = stop ? S_HALT : S_T0;
        else                                      state_nx = state_t'(step + 4'd1);
      end
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {PCout, PCin, incPC, IRin, MARin, MDRin, MDRout, read, write} = '0;
    {Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Cout} = '0;
    {InPortOut, OutPortIn, CONN_in, jal_flag, R15jal} = '0;
    opcode = OP_ADD;
    run    = 1'b1;
    clear  = 1'b0;
    case (state)
      S_RST:  begin run = 1'b0; clear = 1'b1; opcode = '0; end
      S_HALT: begin run = 1'b0; opcode = '0; end
      S_T0:   begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; end
      S_T1:   begin read = 1'b1; MDRin = 1'b1; end
      S_T2:   begin MDRout = 1'b1; IRin = 1'b1; end
      default: begin
        if (is_alu3(op) || is_imm(op)) begin
          case (state)
            S_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            S_T4: begin
              Grc = is_alu3(op); Rout = is_alu3(op); Cout = is_imm(op);
              opcode = op; Zin = 1'b1;
            end
            S_T5: begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end else if (is_unary(op)) begin
          case (state)
            S_T3: begin Grb = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1; end
            S_T4: begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end else if (is_muldiv(op)) begin
          case (state)
            S_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            S_T4: begin Grb = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1; end
            S_T5: begin ZLowOut = 1'b1; LOin = 1'b1; end
            S_T6: begin ZHighOut = 1'b1; HIin = 1'b1; end
            default: ;
          endcase
        end else if (is_mem(op)) begin
          // base+offset address computation is shared by ld, ldi and st
          case (state)
            S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            S_T4: begin Cout = 1'b1; Zin = 1'b1; end
            S_T5: begin
              ZLowOut = 1'b1;
              if (op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
              else MARin = 1'b1;
            end
            S_T6: begin
              MDRin = 1'b1;
              if (op == OP_ST) begin Gra = 1'b1; Rout = 1'b1; end
              else read = 1'b1;
            end
            S_T7: begin
              if (op == OP_ST) write = 1'b1;
              else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            default: ;
          endcase
        end else if (op == OP_BRX) begin
          case (state)
            S_T3: begin Gra = 1'b1; Rout = 1'b1; CONN_in = 1'b1; end
            S_T4: begin PCout = 1'b1; Yin = 1'b1; end
            S_T5: begin Cout = 1'b1; Zin = 1'b1; end
            S_T6: begin ZLowOut = 1'b1; PCin = con_ff; end
            default: ;
          endcase
        end else if (op == OP_JAL) begin
          case (state)
            S_T3: begin PCout = 1'b1; R15jal = 1'b1; jal_flag = 1'b1; end
            S_T4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        end else if (state == S_T3) begin
          case (op)
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: stimulus pushes per-cycle expected control words built from
// textual step lists; a negedge monitor pops and compares every cycle.
module tb_control_unit;

  localparam logic [4:0] K_LD = 5'd0,  K_LDI = 5'd1, K_ST = 5'd2,  K_ADD = 5'd3,
                         K_SHL = 5'd11, K_ADDI = 5'd12, K_ORI = 5'd14, K_DIV = 5'd15,
                         K_MUL = 5'd16, K_NEG = 5'd17, K_NOT = 5'd18, K_BRX = 5'd19,
                         K_JR = 5'd20, K_JAL = 5'd21, K_IN = 5'd22, K_OUT = 5'd23,
                         K_MFHI = 5'd24, K_MFLO = 5'd25, K_HALT = 5'd27;
  localparam int RUN_B = 29;

  logic clock = 1'b0, reset = 1'b0, stop = 1'b0, con_ff = 1'b0;
  logic [31:0] ir = '0;
  logic [4:0] opcode;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCout, PCin, incPC, IRin, MARin, MDRin, MDRout, read, write;
  logic Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, Cout;
  logic InPortOut, OutPortIn, CONN_in, jal_flag, R15jal, run, clear;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .reset(reset), .stop(stop), .ir(ir), .con_ff(con_ff), .opcode(opcode),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .incPC(incPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .read(read), .write(write), .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut),
    .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .InPortOut(InPortOut), .OutPortIn(OutPortIn), .CONN_in(CONN_in), .jal_flag(jal_flag),
    .R15jal(R15jal), .run(run), .clear(clear)
  );

  logic [30:0] got;
  assign got = {clear, run, R15jal, jal_flag, CONN_in, OutPortIn, InPortOut, Cout, LOout,
                HIout, LOin, HIin, ZHighOut, ZLowOut, Zin, Yin, write, read, MDRout, MDRin,
                MARin, IRin, incPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

  function automatic string sig_name(int j);
    case (j)
      0: return "Gra";        1: return "Grb";       2: return "Grc";      3: return "Rin";
      4: return "Rout";       5: return "BAout";     6: return "PCout";    7: return "PCin";
      8: return "incPC";      9: return "IRin";      10: return "MARin";   11: return "MDRin";
      12: return "MDRout";    13: return "read";     14: return "write";   15: return "Yin";
      16: return "Zin";       17: return "ZLowOut";  18: return "ZHighOut"; 19: return "HIin";
      20: return "LOin";      21: return "HIout";    22: return "LOout";   23: return "Cout";
      24: return "InPortOut"; 25: return "OutPortIn"; 26: return "CONN_in"; 27: return "jal_flag";
      28: return "R15jal";    29: return "run";      30: return "clear";
      default: return "";
    endcase
  endfunction

  function automatic logic [30:0] mask(string s);
    logic [30:0] m = '0;
    int st = 0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (i > st) begin
          string t;
          t = s.substr(st, i - 1);
          for (int j = 0; j < 31; j++) if (t == sig_name(j)) m[j] = 1'b1;
        end
        st = i + 1;
      end
    end
    return m;
  endfunction

  // Reference model: instruction length and the signal list of each step.
  function automatic int ilen(logic [4:0] op);
    if (op == K_LD || op == K_ST) return 8;
    if (op == K_MUL || op == K_DIV || op == K_BRX) return 7;
    if (op == K_NEG || op == K_NOT || op == K_JAL) return 5;
    if ((op >= K_ADD && op <= K_ORI) || op == K_LDI) return 6;
    return 4;
  endfunction

  function automatic void step_txt(input logic [4:0] op, input int n, input logic con,
                                   output string s, output logic [4:0] opc);
    opc = K_ADD;
    s = "";
    if (n == 0) s = "PCout MARin incPC";
    else if (n == 1) s = "read MDRin";
    else if (n == 2) s = "MDRout IRin";
    else if (op >= K_ADD && op <= K_SHL) begin
      if (n == 3) s = "Grb Rout Yin";
      if (n == 4) begin s = "Grc Rout Zin"; opc = op; end
      if (n == 5) s = "ZLowOut Gra Rin";
    end else if (op >= K_ADDI && op <= K_ORI) begin
      if (n == 3) s = "Grb Rout Yin";
      if (n == 4) begin s = "Cout Zin"; opc = op; end
      if (n == 5) s = "ZLowOut Gra Rin";
    end else if (op == K_NEG || op == K_NOT) begin
      if (n == 3) begin s = "Grb Rout Zin"; opc = op; end
      if (n == 4) s = "ZLowOut Gra Rin";
    end else if (op == K_MUL || op == K_DIV) begin
      if (n == 3) s = "Gra Rout Yin";
      if (n == 4) begin s = "Grb Rout Zin"; opc = op; end
      if (n == 5) s = "ZLowOut LOin";
      if (n == 6) s = "ZHighOut HIin";
    end else if (op == K_LD || op == K_LDI || op == K_ST) begin
      if (n == 3) s = "Grb BAout Yin";
      if (n == 4) s = "Cout Zin";
      if (n == 5) s = (op == K_LDI) ? "ZLowOut Gra Rin" : "ZLowOut MARin";
      if (n == 6) s = (op == K_LD) ? "read MDRin" : "Gra Rout MDRin";
      if (n == 7) s = (op == K_LD) ? "MDRout Gra Rin" : "write";
    end else if (op == K_BRX) begin
      if (n == 3) s = "Gra Rout CONN_in";
      if (n == 4) s = "PCout Yin";
      if (n == 5) s = "Cout Zin";
      if (n == 6) s = con ? "ZLowOut PCin" : "ZLowOut";
    end else if (op == K_JAL) begin
      if (n == 3) s = "PCout R15jal jal_flag";
      if (n == 4) s = "Gra Rout PCin";
    end else if (op == K_JR)   s = "Gra Rout PCin";
    else if (op == K_IN)       s = "InPortOut Gra Rin";
    else if (op == K_OUT)      s = "Gra Rout OutPortIn";
    else if (op == K_MFHI)     s = "HIout Gra Rin";
    else if (op == K_MFLO)     s = "LOout Gra Rin";
  endfunction

  logic [30:0] q_sig[$];
  logic [4:0]  q_opc[$];
  string       q_tag[$];
  int errors = 0, checks = 0, cyc = 0;

  task automatic push(input logic [30:0] s, input logic [4:0] o, input string tag);
    q_sig.push_back(s);
    q_opc.push_back(o);
    q_tag.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset asserted now for n cycles, then released: n+1 cycles of RST.
  task automatic do_reset(input int n);
    reset = 1'b1;
    push(mask("clear"), 5'd0, "rst");
    for (int i = 1; i < n; i++) begin tick(); push(mask("clear"), 5'd0, "rst"); end
    tick();
    reset = 1'b0;
    push(mask("clear"), 5'd0, "rst_tail");
    tick();
  endtask

  task automatic expect_halt(input int n);
    for (int i = 0; i < n; i++) begin push('0, 5'd0, "halt"); tick(); end
  endtask

  // smode 0: stop toggles randomly mid-instruction, low at the last step.
  // smode 1: stop high from T2 onward. abort>0: only the first abort steps run.
  task automatic run_instr(input logic [4:0] op, input logic con, input int smode, input int abort);
    int len, last;
    string s;
    logic [4:0] opc;
    len  = ilen(op);
    last = (abort > 0) ? abort : len;
    ir = {op, 27'($urandom)};
    for (int n = 0; n < last; n++) begin
      stop   = (smode == 1) ? (n >= 2) : ((n == len - 1) ? 1'b0 : 1'($urandom % 2));
      con_ff = (op == K_BRX && n < 5) ? 1'($urandom % 2) : con;
      step_txt(op, n, con, s, opc);
      push(mask(s) | (31'd1 << RUN_B), opc, $sformatf("op%0d_T%0d", op, n));
      tick();
    end
    stop = 1'b0;
  endtask

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (q_sig.size() > 0) begin
      logic [30:0] es;
      logic [4:0]  eo;
      string       et;
      es = q_sig.pop_front();
      eo = q_opc.pop_front();
      et = q_tag.pop_front();
      checks++;
      if (got !== es || opcode !== eo) begin
        errors++;
        $display("FAIL cyc%0d %s: got ctl=%h opcode=%b, want ctl=%h opcode=%b",
                 cyc, et, got, opcode, es, eo);
      end
    end
  end

  initial begin
    logic [4:0] op;
    int r;
    tick();
    do_reset(3);
    run_instr(K_ADD, 1'b0, 0, 0);
    run_instr(K_LD, 1'b0, 0, 0);
    run_instr(K_ST, 1'b0, 0, 0);
    run_instr(K_BRX, 1'b0, 0, 0);
    run_instr(K_BRX, 1'b1, 0, 0);
    run_instr(K_MUL, 1'b0, 0, 0);
    run_instr(K_HALT, 1'b0, 0, 0);
    expect_halt(20);
    do_reset(2);
    run_instr(K_ADD, 1'b0, 1, 0);
    expect_halt(5);
    do_reset(1);
    run_instr(K_ST, 1'b0, 0, 4);
    do_reset(2);
    for (int k = 0; k < 120; k++) begin
      op = 5'($urandom % 32);
      r  = int'($urandom % 10);
      if (op == K_HALT) begin
        run_instr(op, 1'($urandom % 2), 0, 0);
        expect_halt(3);
        do_reset(1 + int'($urandom % 3));
      end else if (r == 0) begin
        run_instr(op, 1'($urandom % 2), 0, 1 + int'($urandom_range(ilen(op) - 2, 0)));
        do_reset(1);
      end else if (r == 1) begin
        run_instr(op, 1'($urandom % 2), 1, 0);
        expect_halt(2);
        do_reset(1);
      end else begin
        run_instr(op, 1'($urandom % 2), 0, 0);
      end
    end
    for (int i = 0; i < 10 && q_sig.size() > 0; i++) @(negedge clock);
    #1;
    checks++;
    if (q_sig.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q_sig.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
